var_delay_line: RTL and testbench

VAR_DELAY_LINE -- requirements
Module: var_delay_line

---
 rtl/var_delay_line_pkg.sv | 23 ++
 rtl/dly_ring_buf.sv | 45 ++++
 rtl/var_delay_line.sv | 116 +++++++++++
 tb/tb_var_delay_line.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/var_delay_line_pkg.sv
// rtl/var_delay_line_pkg.sv - shared defaults, state encoding and delay clamp for var_delay_line
package var_delay_line_pkg;

   localparam int N_DEF         = 4;
   localparam int MAX_DELAY_DEF = 16;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   // Effective delay: 0 behaves as a single register, anything past the
   // buffer depth saturates at the deepest tap.
   function automatic int unsigned clamp_delay(input int unsigned d, input int unsigned max_d);
      if (d == 0)
         return 1;
      else if (d > max_d)
         return max_d;
      else
         return d;
   endfunction

endpackage

// File: rtl/dly_ring_buf.sv
// rtl/dly_ring_buf.sv - circular history buffer with wrapping write pointer and modulo read
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears pointer and every entry)
//   we         : write enable, stores wdata and advances the write pointer
//   wdata      : entry to store
//   rd_off     : how many writes back to read (1 = entry written on the previous write)
//   rdata      : combinational read of the selected entry
module dly_ring_buf #(
   parameter int W     = 5,
   parameter int DEPTH = 16,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] rd_off,
   output logic [W-1:0]  rdata
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rd_idx;

   // wp points at the slot about to be written, so wp-1 is the newest entry.
   // Adding DEPTH before subtracting keeps the index in range for any depth.
   always_comb begin
      rd_idx = AW'((int'(wp) + DEPTH - int'(rd_off)) % DEPTH);
   end

   assign rdata = mem[rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (we) begin
         mem[wp] <= wdata;
         wp      <= (wp == AW'(DEPTH - 1)) ? '0 : wp + AW'(1);
      end
   end

endmodule

// File: rtl/var_delay_line.sv
// rtl/var_delay_line.sv - runtime-variable delay line with flush on delay change
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   ce     : clock enable, advances the line
//   idata  : sample in (N bits), ivalid qualifies it
//   delay  : requested delay in ce cycles, clamped to 1..MAX_DELAY
//   odata  : delayed sample, registered
//   ovalid : delayed ivalid, held low while flushing
//   busy   : high while a delay change is flushing
//   err    : only with VAR_DELAY_LINE_ERR_EN defined; sticky flag set when a
//            ce edge samples delay=0 or delay>MAX_DELAY, cleared by reset
module var_delay_line
   import var_delay_line_pkg::*;
#(
   parameter int N         = N_DEF,
   parameter int MAX_DELAY = MAX_DELAY_DEF,
   parameter int DW        = $clog2(MAX_DELAY + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ce,
   input  logic [N-1:0]  idata,
   input  logic          ivalid,
   input  logic [DW-1:0] delay,
   output logic [N-1:0]  odata,
   output logic          ovalid,
   output logic          busy
`ifdef VAR_DELAY_LINE_ERR_EN
   ,
   output logic          err
`endif
);

   localparam int AW = $clog2(MAX_DELAY);

   logic [DW-1:0] d_eff;
   logic [DW-1:0] d_q;
   logic          d_loaded;
   logic [DW-1:0] cnt;
   state_t        state;
   logic [AW-1:0] rd_off;
   logic [N:0]    ring_rdata;
   logic [N:0]    tap;

   assign d_eff  = DW'(clamp_delay(32'(delay), MAX_DELAY));
   assign rd_off = AW'(32'(d_eff) - 1);

   dly_ring_buf #(
      .W     (N + 1),
      .DEPTH (MAX_DELAY)
   ) u_ring (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (ce),
      .wdata  ({ivalid, idata}),
      .rd_off (rd_off),
      .rdata  (ring_rdata)
   );

   // D=1 bypasses the buffer: the output register takes this edge's input.
   assign tap = (d_eff == DW'(1)) ? {ivalid, idata} : ring_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         cnt      <= '0;
         d_q      <= '0;
         d_loaded <= 1'b0;
         odata    <= '0;
         ovalid   <= 1'b0;
         busy     <= 1'b0;
      end else if (ce) begin
         odata <= tap[N-1:0];
         if (!d_loaded) begin
            // First ce edge after reset just adopts the delay; the zeroed
            // history already keeps ovalid low until real samples arrive.
            d_loaded <= 1'b1;
            d_q      <= d_eff;
            state    <= RUN;
            busy     <= 1'b0;
            ovalid   <= tap[N];
         end else if (d_eff != d_q) begin
            // Counter holds the remaining busy edges minus one, so busy
            // stays high for exactly d_eff ce edges including this one.
            d_q    <= d_eff;
            state  <= FLUSH;
            cnt    <= d_eff - DW'(1);
            busy   <= 1'b1;
            ovalid <= 1'b0;
         end else if (state == FLUSH) begin
            if (cnt == '0) begin
               state  <= RUN;
               busy   <= 1'b0;
               ovalid <= tap[N];
            end else begin
               cnt    <= cnt - DW'(1);
               ovalid <= 1'b0;
            end
         end else begin
            ovalid <= tap[N];
         end
      end
   end

`ifdef VAR_DELAY_LINE_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err <= 1'b0;
      else if (ce && ((delay == '0) || (delay > DW'(MAX_DELAY))))
         err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_var_delay_line.sv
// tb/tb_var_delay_line.sv - self-checking bench for var_delay_line against a history-queue model
module tb_var_delay_line;

   localparam int N         = 4;
   localparam int MAX_DELAY = 16;
   localparam int DW        = 5;

   logic          clk;
   logic          rst_n;
   logic          ce;
   logic [N-1:0]  idata;
   logic          ivalid;
   logic [DW-1:0] delay;
   logic [N-1:0]  odata;
   logic          ovalid;
   logic          busy;
`ifdef VAR_DELAY_LINE_ERR_EN
   logic          err;
`endif

   int checks;
   int errors;

   // Reference model: every ce-edge sample since reset, newest at the back.
   logic [N:0]   hist[$];
   bit           m_loaded;
   int           m_stored;
   int           m_left;
   logic [N-1:0] e_odata;
   logic         e_ovalid;
   logic         e_busy;
   logic         e_err;

   var_delay_line #(
      .N         (N),
      .MAX_DELAY (MAX_DELAY),
      .DW        (DW)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ce     (ce),
      .idata  (idata),
      .ivalid (ivalid),
      .delay  (delay),
      .odata  (odata),
      .ovalid (ovalid),
      .busy   (busy)
`ifdef VAR_DELAY_LINE_ERR_EN
      ,
      .err    (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_clamp(input int d);
      if (d < 1)
         return 1;
      if (d > MAX_DELAY)
         return MAX_DELAY;
      return d;
   endfunction

   task automatic model_reset();
      hist.delete();
      m_loaded = 0;
      m_stored = 0;
      m_left   = 0;
      e_odata  = '0;
      e_ovalid = 1'b0;
      e_busy   = 1'b0;
      e_err    = 1'b0;
   endtask

   // Drive one cycle, advance the model on ce edges, settle 1ns past the edge.
   task automatic step(input logic c, input int d, input logic v, input logic [N-1:0] x);
      int         dd;
      int         idx;
      logic [N:0] s;
      ce     = c;
      delay  = DW'(d);
      ivalid = v;
      idata  = x;
      @(posedge clk);
      if (c) begin
         dd = model_clamp(d);
         hist.push_back({v, x});
         idx = hist.size() - dd;
         s   = (idx >= 0) ? hist[idx] : '0;
         if (d == 0 || d > MAX_DELAY)
            e_err = 1'b1;
         if (!m_loaded) begin
            m_loaded = 1;
            m_stored = dd;
         end else if (dd != m_stored) begin
            m_stored = dd;
            m_left   = dd;
         end else if (m_left > 0) begin
            m_left--;
         end
         e_busy   = (m_left > 0);
         e_odata  = s[N-1:0];
         e_ovalid = s[N] && !e_busy;
      end
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      ce = 1'b0; idata = '0; ivalid = 1'b0; delay = '0;
      rst_n = 1'b0;
      #3;
      model_reset();
      checks++;
      if (odata !== '0 || ovalid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got odata=%0h ovalid=%0b busy=%0b want 0 0 0", odata, ovalid, busy);
      end
`ifdef VAR_DELAY_LINE_ERR_EN
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL reset_err: got %0b want 0", err);
      end
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_delay1();
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1, 1'b1, N'(i));
         checks++;
         if (odata !== N'(i) || ovalid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL delay1[%0d]: got odata=%0h ovalid=%0b busy=%0b want %0h 1 0", i, odata, ovalid, busy, i);
         end
      end
   endtask

   task automatic test_delay5_ramp();
      logic [N-1:0] want_d;
      logic         want_v;
      apply_reset();
      for (int k = 1; k <= 15; k++) begin
         step(1'b1, 5, 1'b1, N'(k));
         want_d = (k >= 5) ? N'(k - 4) : '0;
         want_v = (k >= 5);
         checks++;
         if (odata !== want_d || ovalid !== want_v || busy !== 1'b0) begin
            errors++;
            $display("FAIL delay5_ramp[%0d]: got odata=%0h ovalid=%0b busy=%0b want %0h %0b 0", k, odata, ovalid, busy, want_d, want_v);
         end
      end
   endtask

   task automatic test_delay_change();
      int busy_edges;
      int r;
      busy_edges = 0;
      r = 15;
      for (int k = 0; k < 14; k++) begin
         r++;
         step(1'b1, 8, 1'b1, N'(r));
         if (busy === 1'b1)
            busy_edges++;
         checks++;
         if (odata !== e_odata || ovalid !== e_ovalid || busy !== e_busy || (busy === 1'b1 && ovalid !== 1'b0)) begin
            errors++;
            $display("FAIL change_5_8[%0d]: got odata=%0h ovalid=%0b busy=%0b want %0h %0b %0b", k, odata, ovalid, busy, e_odata, e_ovalid, e_busy);
         end
      end
      checks++;
      if (busy_edges != 8) begin
         errors++;
         $display("FAIL change_busy_len: got %0d busy edges want 8", busy_edges);
      end
      checks++;
      if (odata !== N'(r - 7) || ovalid !== 1'b1) begin
         errors++;
         $display("FAIL change_offset: got odata=%0h ovalid=%0b want %0h 1", odata, ovalid, N'(r - 7));
      end
   endtask

   task automatic test_ce_toggle();
      logic [N-1:0] prev;
      for (int k = 0; k < 40; k++) begin
         prev = odata;
         step(k[0] ? 1'b0 : 1'b1, 3, 1'b1, N'($urandom_range(0, 15)));
         checks++;
         if (odata !== e_odata || ovalid !== e_ovalid || busy !== e_busy || (k[0] && odata !== prev)) begin
            errors++;
            $display("FAIL ce_toggle[%0d]: got odata=%0h ovalid=%0b busy=%0b want %0h %0b %0b", k, odata, ovalid, busy, e_odata, e_ovalid, e_busy);
         end
      end
   endtask

   task automatic test_clamp();
      for (int k = 0; k < 40; k++) begin
         step(1'b1, (k < 12) ? 0 : 20, $urandom_range(0, 1) == 1, N'($urandom_range(0, 15)));
         checks++;
         if (odata !== e_odata || ovalid !== e_ovalid || busy !== e_busy) begin
            errors++;
            $display("FAIL clamp[%0d]: got odata=%0h ovalid=%0b busy=%0b want %0h %0b %0b", k, odata, ovalid, busy, e_odata, e_ovalid, e_busy);
         end
`ifdef VAR_DELAY_LINE_ERR_EN
         checks++;
         if (err !== e_err) begin
            errors++;
            $display("FAIL clamp_err[%0d]: got %0b want %0b", k, err, e_err);
         end
`endif
      end
   endtask

   task automatic test_random();
      int d;
      d = 7;
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 19) == 0)
            d = $urandom_range(0, 20);
         step($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0, N'($urandom_range(0, 15)));
         checks++;
         if (odata !== e_odata || ovalid !== e_ovalid || busy !== e_busy) begin
            errors++;
            $display("FAIL random[%0d]: got odata=%0h ovalid=%0b busy=%0b want %0h %0b %0b", k, odata, ovalid, busy, e_odata, e_ovalid, e_busy);
         end
      end
   endtask

   task automatic test_reset_in_flush();
      apply_reset();
      for (int k = 0; k < 10; k++)
         step(1'b1, 5, 1'b1, N'(k + 3));
      for (int k = 0; k < 3; k++)
         step(1'b1, 12, 1'b1, N'(k + 9));
      checks++;
      if (busy !== 1'b1 || ovalid !== 1'b0) begin
         errors++;
         $display("FAIL flush_before_reset: got busy=%0b ovalid=%0b want 1 0", busy, ovalid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (odata !== '0 || ovalid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_flush: got odata=%0h ovalid=%0b busy=%0b want 0 0 0", odata, ovalid, busy);
      end
`ifdef VAR_DELAY_LINE_ERR_EN
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_cleared: got %0b want 0", err);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 14; k++) begin
         step(1'b1, 12, 1'b0, N'($urandom_range(0, 15)));
         checks++;
         if (ovalid !== 1'b0 || busy !== 1'b0 || odata !== e_odata) begin
            errors++;
            $display("FAIL post_reset_stale[%0d]: got odata=%0h ovalid=%0b busy=%0b want %0h 0 0", k, odata, ovalid, busy, e_odata);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_delay1();
      test_delay5_ramp();
      test_delay_change();
      test_ce_toggle();
      test_clamp();
      test_random();
      test_reset_in_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
